// File: rtl/s_axis_cc_adapt_x8_if.sv
// Completer-completion stream bundle: legacy 3DW-header TLP side and UltraScale CC side.
// master drives legacy beats and IP-side ready; slave is the adapter.
interface s_axis_cc_adapt_x8_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata;
  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep;
  logic                     s_axis_cc_tlast;
  logic                     s_axis_cc_tvalid;
  logic                     s_axis_cc_tready;
  logic [3:0]               s_axis_cc_tuser;
  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a;
  logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep_a;
  logic                     s_axis_cc_tlast_a;
  logic                     s_axis_cc_tvalid_a;
  logic [3:0]               s_axis_cc_tready_a;
  logic [32:0]              s_axis_cc_tuser_a;

  modport master (
    output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid, s_axis_cc_tuser,
    input  s_axis_cc_tready,
    input  s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tvalid_a, s_axis_cc_tuser_a,
    output s_axis_cc_tready_a
  );

  modport slave (
    input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast, s_axis_cc_tvalid, s_axis_cc_tuser,
    output s_axis_cc_tready,
    output s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tvalid_a, s_axis_cc_tuser_a,
    input  s_axis_cc_tready_a
  );
endinterface

// File: rtl/s_axis_cc_adapt_x8.sv
// Legacy completion TLP -> UltraScale CC descriptor adapter with 2-entry output skid buffer.
// Optional length check / discontinue / DROP state: define LITEPCIE_CC_LEN_CHECK_EN.
module s_axis_cc_adapt_x8 #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic user_clk,
  input  logic user_reset,
  s_axis_cc_adapt_x8_if.slave bus
);
  localparam int DW_N = KEEP_WIDTH/4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DW_N-1:0]       keep;
    logic                  last;
    logic                  disc;
  } beat_t;

  logic                  acc, hdr, push_en, pop, last_o, disc_o, rdy;
  logic [DW_N-1:0]       keep_dw;
  logic [31:0]           dw0, dw1, dw2;
  logic [10:0]           dw_cnt;
  logic [12:0]           byte_cnt;
  logic [95:0]           desc;
  logic [1:0]            cnt, cnt_nxt;
  beat_t                 in_beat, head, skid;
  logic                  unused_ok;

  assign acc       = bus.s_axis_cc_tvalid & rdy;
  assign unused_ok = ^{bus.s_axis_cc_tuser, bus.s_axis_cc_tready_a[3:1], bus.s_axis_cc_tkeep};

  for (genvar i = 0; i < DW_N; i++) begin : g_keep
    assign keep_dw[i] = bus.s_axis_cc_tkeep[4*i];
  end

  // Legacy DW0..DW2 -> CC descriptor; unlisted descriptor bits stay 0.
  always_comb begin
    dw0      = bus.s_axis_cc_tdata[31:0];
    dw1      = bus.s_axis_cc_tdata[63:32];
    dw2      = bus.s_axis_cc_tdata[95:64];
    dw_cnt   = '0;
    if (dw0[30]) dw_cnt = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
    byte_cnt = (dw1[11:0] == 12'd0) ? 13'd4096 : {1'b0, dw1[11:0]};
    desc          = '0;
    desc[6:0]     = dw2[6:0];
    desc[28:16]   = byte_cnt;
    desc[29]      = (dw0[28:24] == 5'b01011);
    desc[42:32]   = dw_cnt;
    desc[45:43]   = dw1[15:13];
    desc[46]      = dw0[14];
    desc[63:48]   = dw2[31:16];
    desc[71:64]   = dw2[15:8];
    desc[87:72]   = dw1[31:16];
    desc[91:89]   = dw0[22:20];
    desc[94:92]   = {1'b0, dw0[13:12]};
  end

`ifdef LITEPCIE_CC_LEN_CHECK_EN
  typedef enum logic [1:0] {HDR, BODY, DROP} state_t;
  state_t     state, state_nxt;
  logic [7:0] beats_left, beats_nxt, rem, hdr_bl;

  assign hdr_bl = 8'((dw_cnt + 11'd10) >> 3) - 8'd1;
  assign hdr    = (state == HDR);

  // rem = beats still owed after the current one
  always_comb begin
    state_nxt = state;
    beats_nxt = beats_left;
    last_o    = bus.s_axis_cc_tlast;
    disc_o    = 1'b0;
    push_en   = acc & (state != DROP);
    case (state)
      HDR:     rem = hdr_bl;
      BODY:    rem = beats_left - 8'd1;
      default: rem = '0;
    endcase
    if (acc) begin
      case (state)
        HDR, BODY: begin
          if (bus.s_axis_cc_tlast) begin
            state_nxt = HDR;
            beats_nxt = '0;
            disc_o    = (rem != 8'd0);
          end else if (rem == 8'd0) begin
            state_nxt = DROP;
            beats_nxt = '0;
            last_o    = 1'b1;
            disc_o    = 1'b1;
          end else begin
            state_nxt = BODY;
            beats_nxt = rem;
          end
        end
        default: if (bus.s_axis_cc_tlast) state_nxt = HDR;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state      <= HDR;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_nxt;
    end
  end
`else
  logic in_pkt;

  assign hdr     = ~in_pkt;
  assign last_o  = bus.s_axis_cc_tlast;
  assign disc_o  = 1'b0;
  assign push_en = acc;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset)  in_pkt <= 1'b0;
    else if (acc)    in_pkt <= ~bus.s_axis_cc_tlast;
  end
`endif

  always_comb begin
    in_beat.data = hdr ? {bus.s_axis_cc_tdata[DATA_WIDTH-1:96], desc} : bus.s_axis_cc_tdata;
    in_beat.keep = keep_dw;
    in_beat.last = last_o;
    in_beat.disc = disc_o;
  end

  // head drives the IP; skid catches the beat that lands while the IP stalls
  assign pop = (cnt != 2'd0) & bus.s_axis_cc_tready_a[0];

  always_comb begin
    cnt_nxt = cnt;
    if (push_en & ~pop)      cnt_nxt = cnt + 2'd1;
    else if (~push_en & pop) cnt_nxt = cnt - 2'd1;
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      head <= '0;
      skid <= '0;
      cnt  <= '0;
      rdy  <= 1'b0;
    end else begin
      case ({push_en, pop})
        2'b10: if (cnt == 2'd0) head <= in_beat; else skid <= in_beat;
        2'b01: if (cnt == 2'd2) head <= skid;
        2'b11: begin
          if (cnt == 2'd2) begin
            head <= skid;
            skid <= in_beat;
          end else begin
            head <= in_beat;
          end
        end
        default: ;
      endcase
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt != 2'd2);
    end
  end

  assign bus.s_axis_cc_tready   = rdy;
  assign bus.s_axis_cc_tdata_a  = head.data;
  assign bus.s_axis_cc_tkeep_a  = head.keep;
  assign bus.s_axis_cc_tlast_a  = head.last;
  assign bus.s_axis_cc_tuser_a  = {32'd0, head.disc};
  assign bus.s_axis_cc_tvalid_a = (cnt != 2'd0);
endmodule

// File: tb/tb_s_axis_cc_adapt_x8.sv
// Directed bench for s_axis_cc_adapt_x8: scoreboard of expected CC beats, monitor on the IP side.
module tb_s_axis_cc_adapt_x8;
`ifdef LITEPCIE_CC_LEN_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  typedef struct {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         last;
    logic [32:0]  user;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   tog = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  s_axis_cc_adapt_x8_if #(.DATA_WIDTH(256)) bus ();

  s_axis_cc_adapt_x8 #(.DATA_WIDTH(256)) dut (
    .user_clk  (clk),
    .user_reset(rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transfers happen at the next posedge; inputs only move at posedge+1.
  always @(negedge clk) begin
    if (!rst && bus.s_axis_cc_tvalid_a && bus.s_axis_cc_tready_a[0]) begin
      if (sb.size() == 0) begin
        chk("extra_beat", 256'(sb.size() + 1), 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", bus.s_axis_cc_tdata_a, e.data);
        chk("keep_last_user",
            256'({bus.s_axis_cc_tkeep_a, bus.s_axis_cc_tlast_a, bus.s_axis_cc_tuser_a}),
            256'({e.keep, e.last, e.user}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) bus.s_axis_cc_tready_a[0] = ~bus.s_axis_cc_tready_a[0];
  endtask

  task automatic drive(input logic [255:0] d, input logic [31:0] k, input logic l);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.s_axis_cc_tdata  = d;
    bus.s_axis_cc_tkeep  = k;
    bus.s_axis_cc_tlast  = l;
    bus.s_axis_cc_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.s_axis_cc_tready;
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 256'(acc), 256'd1);
    bus.s_axis_cc_tvalid = 1'b0;
  endtask

  function automatic logic [95:0] mk_hdr(input bit fd, input logic [4:0] typ, input logic [2:0] tc,
      input logic [1:0] attr, input bit ep, input logic [9:0] len, input logic [15:0] cpl,
      input logic [2:0] st, input logic [11:0] bc, input logic [15:0] req, input logic [7:0] tag,
      input logic [6:0] la);
    logic [31:0] d0, d1, d2;
    d0 = '0; d1 = '0; d2 = '0;
    d0[30] = fd; d0[28:24] = typ; d0[22:20] = tc; d0[14] = ep; d0[13:12] = attr; d0[9:0] = len;
    d1[31:16] = cpl; d1[15:13] = st; d1[11:0] = bc;
    d2[31:16] = req; d2[15:8] = tag; d2[6:0] = la;
    return {d2, d1, d0};
  endfunction

  function automatic logic [95:0] mk_desc(input logic [10:0] dwc, input logic [12:0] bc, input bit lk,
      input logic [6:0] la, input logic [2:0] st, input bit ep, input logic [15:0] req,
      input logic [7:0] tag, input logic [15:0] cpl, input logic [2:0] tc, input logic [1:0] attr);
    logic [95:0] r;
    r = '0;
    r[6:0] = la; r[28:16] = bc; r[29] = lk; r[42:32] = dwc; r[45:43] = st; r[46] = ep;
    r[63:48] = req; r[71:64] = tag; r[87:72] = cpl; r[91:89] = tc; r[93:92] = attr;
    return r;
  endfunction

  task automatic send_pkt(input logic [95:0] h, input logic [95:0] dsc, input int nin,
      input logic [31:0] lk, input int nout, input bit disc);
    for (int i = 0; i < nin; i++) begin
      logic [255:0] d;
      logic [31:0]  k;
      exp_t         e;
      for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
      if (i == 0) d[95:0] = h;
      k = (i == nin - 1) ? lk : 32'hFFFF_FFFF;
      if (i < nout) begin
        e.data = (i == 0) ? {d[255:96], dsc} : d;
        for (int b = 0; b < 8; b++) e.keep[b] = k[4*b];
        e.last = (i == nout - 1);
        e.user = {32'd0, (i == nout - 1) && disc};
        sb.push_back(e);
      end
      drive(d, k, i == nin - 1);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 256'(sb.size()), 256'd0);
    repeat (3) tick();
    chk({tag, "_idle"}, 256'(bus.s_axis_cc_tvalid_a), 256'd0);
  endtask

  initial begin
    logic [95:0] h, d;
    bus.s_axis_cc_tdata    = '0;
    bus.s_axis_cc_tkeep    = '0;
    bus.s_axis_cc_tlast    = 1'b0;
    bus.s_axis_cc_tvalid   = 1'b0;
    bus.s_axis_cc_tuser    = '0;
    bus.s_axis_cc_tready_a = 4'b0001;

    // reset state
    repeat (3) tick();
    chk("rst_tready",  256'(bus.s_axis_cc_tready),   256'd0);
    chk("rst_tvalid",  256'(bus.s_axis_cc_tvalid_a), 256'd0);
    chk("rst_tdata",   bus.s_axis_cc_tdata_a,        256'd0);
    chk("rst_ctl",     256'({bus.s_axis_cc_tkeep_a, bus.s_axis_cc_tlast_a, bus.s_axis_cc_tuser_a}), 256'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_tready", 256'(bus.s_axis_cc_tready), 256'd1);

    // CplD single beat
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd1, 16'h0200, 3'd0, 12'd4, 16'h0100, 8'h2A, 7'h10);
    d = mk_desc(11'd1, 13'd4, 0, 7'h10, 3'd0, 0, 16'h0100, 8'h2A, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 1, 32'h0000_FFFF, 1, 0);
    drain("cpld1");

    // length-16 CplD twice, back-to-back, IP ready toggling
    tog = 1'b1;
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd16, 16'h0200, 3'd0, 12'd64, 16'h0100, 8'h05, 7'h00);
    d = mk_desc(11'd16, 13'd64, 0, 7'h00, 3'd0, 0, 16'h0100, 8'h05, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 3, 32'h0000_0FFF, 3, 0);
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd16, 16'h0200, 3'd0, 12'd64, 16'h0100, 8'h06, 7'h40);
    d = mk_desc(11'd16, 13'd64, 0, 7'h40, 3'd0, 0, 16'h0100, 8'h06, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 3, 32'h0000_0FFF, 3, 0);
    drain("b2b_stall");
    tog = 1'b0;
    bus.s_axis_cc_tready_a = 4'b0001;

    // Cpl without data, UR status
    h = mk_hdr(0, 5'b01010, 3'd0, 2'd0, 0, 10'd1, 16'h0200, 3'b001, 12'd4, 16'h0100, 8'h11, 7'h00);
    d = mk_desc(11'd0, 13'd4, 0, 7'h00, 3'b001, 0, 16'h0100, 8'h11, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 1, 32'h0000_0FFF, 1, 0);
    drain("cpl_ur");

    // maximum-length encodings: 1024 DW, 4096 bytes, 129 beats
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd0, 16'h0200, 3'd0, 12'd0, 16'h0100, 8'h33, 7'h00);
    d = mk_desc(11'd1024, 13'd4096, 0, 7'h00, 3'd0, 0, 16'h0100, 8'h33, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 129, 32'h0000_0FFF, 129, 0);
    drain("maxlen");

    // early tlast on a length-16 packet, then a locked completion with TC/attr/EP set
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd16, 16'h0200, 3'd0, 12'd64, 16'h0100, 8'h44, 7'h00);
    d = mk_desc(11'd16, 13'd64, 0, 7'h00, 3'd0, 0, 16'h0100, 8'h44, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 2, 32'hFFFF_FFFF, 2, LC);
    h = mk_hdr(1, 5'b01011, 3'd5, 2'b10, 1, 10'd1, 16'hBEEF, 3'b010, 12'd3, 16'hCAFE, 8'h45, 7'h7C);
    d = mk_desc(11'd1, 13'd3, 1, 7'h7C, 3'b010, 1, 16'hCAFE, 8'h45, 16'hBEEF, 3'd5, 2'b10);
    send_pkt(h, d, 1, 32'h0000_FFFF, 1, 0);
    drain("early_last");

    // length-1 packet stretched to 3 beats, then a normal packet
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd1, 16'h0200, 3'd0, 12'd4, 16'h0100, 8'h55, 7'h08);
    d = mk_desc(11'd1, 13'd4, 0, 7'h08, 3'd0, 0, 16'h0100, 8'h55, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 3, 32'h0000_0FFF, LC ? 1 : 3, LC);
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd1, 16'h0200, 3'd0, 12'd4, 16'h0100, 8'h56, 7'h0C);
    d = mk_desc(11'd1, 13'd4, 0, 7'h0C, 3'd0, 0, 16'h0100, 8'h56, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 1, 32'h0000_FFFF, 1, 0);
    drain("late_end");

    // reset during beat 2 of a 3-beat packet; buffered beat 1 must vanish
    bus.s_axis_cc_tready_a = 4'b0000;
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd16, 16'h0200, 3'd0, 12'd64, 16'h0100, 8'h66, 7'h00);
    d = mk_desc(11'd16, 13'd64, 0, 7'h00, 3'd0, 0, 16'h0100, 8'h66, 16'h0200, 3'd0, 2'd0);
    send_pkt(h, d, 1, 32'hFFFF_FFFF, 1, 0);
    chk("pre_rst_valid", 256'(bus.s_axis_cc_tvalid_a), 256'd1);
    bus.s_axis_cc_tdata  = {8{32'h1234_5678}};
    bus.s_axis_cc_tkeep  = 32'hFFFF_FFFF;
    bus.s_axis_cc_tlast  = 1'b0;
    bus.s_axis_cc_tvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 256'(bus.s_axis_cc_tvalid_a), 256'd0);
    chk("midrst_tready", 256'(bus.s_axis_cc_tready),   256'd0);
    sb.delete();
    bus.s_axis_cc_tvalid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    bus.s_axis_cc_tready_a = 4'b0001;
    tick();
    chk("rel_tready", 256'(bus.s_axis_cc_tready),   256'd1);
    chk("rel_tvalid", 256'(bus.s_axis_cc_tvalid_a), 256'd0);
    h = mk_hdr(1, 5'b01010, 3'd0, 2'd0, 0, 10'd1, 16'h0201, 3'd0, 12'd4, 16'h0101, 8'h77, 7'h14);
    d = mk_desc(11'd1, 13'd4, 0, 7'h14, 3'd0, 0, 16'h0101, 8'h77, 16'h0201, 3'd0, 2'd0);
    send_pkt(h, d, 1, 32'h0000_FFFF, 1, 0);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
